cop_host_seq: RTL

- Upstream host sequencer for the 4-bit ADDI coprocessor.
- Holds a small 4-bit register file and accepts ADD-immediate commands (imm, rs, rd).
- Drives the coprocessor opcode/immediate pins, answers its bus requests with the source-register value, and writes the result and carry back into the register file.
- Sits between the test/host logic and the coprocessor pin interface.

---
 rtl/cop_host_seq_pkg.sv | 18 +
 rtl/cop_host_seq_if.sv | 24 ++
 rtl/cop_host_seq_regfile.sv | 33 +++
 rtl/cop_host_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cop_host_seq_pkg.sv
// Shared opcodes, bus request codes and sequencer states for the ADDI
// coprocessor host.
package cop_pkg;

    localparam logic [3:0] OPC_NOP     = 4'd0;
    localparam logic [3:0] OPC_ADDI    = 4'd1;
    localparam logic [3:0] REQ_OPERAND = 4'b0011;
    localparam logic [3:0] REQ_VALUE   = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_SERVE,
        ST_WAIT_DONE,
        ST_WRITEBACK
    } state_t;

endpackage

// File: rtl/cop_host_seq_if.sv
// Coprocessor pin bundle: the host drives opcode/immediate/bus, the
// coprocessor drives request code, result, carry and done.
interface cop_host_seq_if;

    logic [3:0] cop_opcode;
    logic [3:0] cop_imm;
    logic [3:0] cop_bus_req;
    logic [3:0] cop_bus_out;
    logic       cop_bus_oe;
    logic [3:0] cop_result;
    logic       cop_carry;
    logic       cop_done;

    modport master (
        output cop_opcode, cop_imm, cop_bus_out, cop_bus_oe,
        input  cop_bus_req, cop_result, cop_carry, cop_done
    );

    modport slave (
        input  cop_opcode, cop_imm, cop_bus_out, cop_bus_oe,
        output cop_bus_req, cop_result, cop_carry, cop_done
    );

endinterface

// File: rtl/cop_host_seq_regfile.sv
// 4-bit register file: one synchronous write port, two asynchronous read
// ports (operand source and debug).
module cop_regfile #(
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [3:0]    i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [3:0]    o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [3:0]    o_rdata_b
);

    logic [3:0] r_mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cop_host_seq.sv
// Host sequencer: issues ADDI commands to the coprocessor, serves its operand
// request from the register file and writes the result/carry back.
module cop_host_seq
    import cop_pkg::*;
#(
    parameter  int NREGS   = 8,
    parameter  int TIMEOUT = 15,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_imm,
    input  logic [AW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_rd,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data,
    output logic          flag_c,
    output logic          rsp_valid,
    output logic          err,
    cop_host_seq_if.master cop
);

    state_t        r_state, w_state_next;
    logic [3:0]    r_wdog;
    logic [3:0]    w_wdog_inc;
    logic          r_val_seen, r_armed, r_err, r_flag_c, r_carry;
    logic [AW-1:0] r_rs, r_rd;
    logic [3:0]    r_result, r_opcode, r_imm, r_bus_out;
    logic          r_bus_oe;
    logic          w_accept, w_grant, w_release, w_capture, w_abort, w_expire;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [3:0]    w_wdata, w_rs_data;

    cop_regfile #(.NREGS(NREGS)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (r_rs),
        .o_rdata_a (w_rs_data),
        .i_raddr_b (rd_addr),
        .o_rdata_b (rd_data)
    );

    assign w_wdog_inc = r_wdog + 4'd1;
    assign w_expire   = (w_wdog_inc == 4'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Progress in a wait state takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_grant      = 1'b0;
        w_release    = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: if (cmd_valid) begin
                w_accept     = 1'b1;
                w_state_next = ST_WAIT_REQ;
            end
            ST_WAIT_REQ: if (cop.cop_bus_req == REQ_OPERAND) begin
                w_grant      = 1'b1;
                w_state_next = ST_SERVE;
            end else if (w_expire) w_abort = 1'b1;
            ST_SERVE: if (r_val_seen) begin
                w_release    = 1'b1;
                w_state_next = ST_WAIT_DONE;
            end else if (w_expire) w_abort = 1'b1;
            ST_WAIT_DONE: if (cop.cop_done && r_armed) begin
                w_capture    = 1'b1;
                w_state_next = ST_WRITEBACK;
            end else if (w_expire) w_abort = 1'b1;
            ST_WRITEBACK: w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
        if (w_abort) w_state_next = ST_IDLE;
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = wr_addr;
        w_wdata = wr_data;
        if (r_state == ST_WRITEBACK) begin
            w_we    = 1'b1;
            w_waddr = r_rd;
            w_wdata = r_result;
        end else if (r_state == ST_IDLE) begin
            w_we    = wr_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog     <= '0;
            r_val_seen <= 1'b0;
            r_armed    <= 1'b0;
            r_err      <= 1'b0;
            r_flag_c   <= 1'b0;
            r_carry    <= 1'b0;
            r_rs       <= '0;
            r_rd       <= '0;
            r_result   <= '0;
            r_opcode   <= OPC_NOP;
            r_imm      <= '0;
            r_bus_out  <= '0;
            r_bus_oe   <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (r_state != w_state_next || r_state == ST_IDLE || r_state == ST_WRITEBACK)
                r_wdog <= '0;
            else
                r_wdog <= w_wdog_inc;
            if (w_accept) begin
                r_rs     <= cmd_rs;
                r_rd     <= cmd_rd;
                r_imm    <= cmd_imm;
                r_opcode <= OPC_ADDI;
                r_armed  <= 1'b0;
            end
            if (w_grant) begin
                r_bus_out  <= w_rs_data;
                r_bus_oe   <= 1'b1;
                r_val_seen <= 1'b0;
            end
            if (r_state == ST_SERVE && cop.cop_bus_req == REQ_VALUE) r_val_seen <= 1'b1;
            if (w_release || w_abort) r_bus_oe <= 1'b0;
            // A done left high by the previous op only counts after it has been seen low.
            if (r_state == ST_WAIT_DONE && !cop.cop_done) r_armed <= 1'b1;
            if (w_capture) begin
                r_result <= cop.cop_result;
                r_carry  <= cop.cop_carry;
            end
            if (w_capture || w_abort) r_opcode <= OPC_NOP;
            if (r_state == ST_WRITEBACK) r_flag_c <= r_carry;
        end
    end

    assign cmd_ready       = (r_state == ST_IDLE);
    assign rsp_valid       = (r_state == ST_WRITEBACK);
    assign err             = r_err;
    assign flag_c          = r_flag_c;
    assign cop.cop_opcode  = r_opcode;
    assign cop.cop_imm     = r_imm;
    assign cop.cop_bus_out = r_bus_out;
    assign cop.cop_bus_oe  = r_bus_oe;

endmodule
